// File: rtl/leaf_collect_pkg.sv
// Shared types and helpers for the leaf stream collector.
// Source-index width and default FIFO entry layout.
package leaf_collect_pkg;

  localparam int N_SRC_DEF  = 5;
  localparam int DATA_W_DEF = 16;

  function automatic int src_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int SRC_W_DEF = src_w(N_SRC_DEF);

  typedef struct packed {
    logic [SRC_W_DEF-1:0]  src;
    logic [DATA_W_DEF-1:0] data;
  } entry_t;

endpackage

// File: rtl/leaf_rr_arbiter.sv
// Round-robin arbiter: first requester at or after ptr, modulo N.
// Grant is one-hot and gated by enable.
module leaf_rr_arbiter
  import leaf_collect_pkg::*;
#(
  parameter int N = N_SRC_DEF,
  localparam int PW = src_w(N)
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  input  logic          enable,
  output logic [N-1:0]  grant,
  output logic [PW-1:0] grant_idx,
  output logic          any_grant
);

  logic          found_hi;
  logic          found_lo;
  logic [PW-1:0] hi_idx;
  logic [PW-1:0] lo_idx;

  // Descending scan leaves the lowest index in each half.
  always_comb begin
    found_hi = 1'b0;
    found_lo = 1'b0;
    hi_idx   = '0;
    lo_idx   = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req[i]) begin
        if (PW'(i) >= ptr) begin
          hi_idx   = PW'(i);
          found_hi = 1'b1;
        end else begin
          lo_idx   = PW'(i);
          found_lo = 1'b1;
        end
      end
    end
  end

  always_comb begin
    grant     = '0;
    grant_idx = found_hi ? hi_idx : lo_idx;
    any_grant = (found_hi || found_lo) && enable;
    if (any_grant) grant[grant_idx] = 1'b1;
  end

endmodule

// File: rtl/leaf_stream_collector.sv
// Merges N_SRC leaf streams round-robin into one FIFO-buffered
// output stream, tagging each word with its source index.
module leaf_stream_collector
  import leaf_collect_pkg::*;
#(
  parameter int N_SRC  = N_SRC_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int DEPTH  = 4,
  localparam int SW = src_w(N_SRC),
  localparam int AW = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [N_SRC-1:0]      in_valid,
  input  logic [N_SRC*DATA_W-1:0] in_data,
  output logic [N_SRC-1:0]      in_ready,
  output logic                  out_valid,
  output logic [DATA_W-1:0]     out_data,
  output logic [SW-1:0]         out_src,
  input  logic                  out_ready,
  output logic [AW:0]           fill_level
);

  typedef struct packed {
    logic [SW-1:0]     src;
    logic [DATA_W-1:0] data;
  } ent_t;

  logic [DATA_W-1:0] words [N_SRC];
  ent_t              mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic [SW-1:0]     rr_ptr;
  logic [SW-1:0]     grant_idx;
  logic [N_SRC-1:0]  grant;
  logic              any_grant;
  logic              full;
  logic              empty;
  logic              push;
  logic              pop;

  for (genvar i = 0; i < N_SRC; i++) begin : g_words
    assign words[i] = in_data[i*DATA_W +: DATA_W];
  end

  assign full  = fill_level == (AW+1)'(DEPTH);
  assign empty = fill_level == '0;

  // Ready stays low while reset is held, even though the FIFO is empty.
  leaf_rr_arbiter #(.N(N_SRC)) u_arb (
    .req       (in_valid),
    .ptr       (rr_ptr),
    .enable    (!full && !rst),
    .grant     (grant),
    .grant_idx (grant_idx),
    .any_grant (any_grant)
  );

  assign in_ready  = grant;
  assign push      = any_grant;
  assign pop       = !empty && out_ready;
  assign out_valid = !empty;
  assign out_data  = mem[rd_ptr].data;
  assign out_src   = mem[rd_ptr].src;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      rr_ptr     <= '0;
      fill_level <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= '{src: grant_idx, data: words[grant_idx]};
        wr_ptr      <= wr_ptr + 1'b1;
        rr_ptr      <= (grant_idx == SW'(N_SRC - 1)) ? '0
                                                     : grant_idx + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)      fill_level <= fill_level + 1'b1;
      else if (pop && !push) fill_level <= fill_level - 1'b1;
    end
  end

endmodule

// File: tb/tb_leaf_stream_collector.sv
// Bench for leaf_stream_collector: scoreboard monitor plus
// per-scenario directed tasks.
module tb_leaf_stream_collector;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  in_valid;
  logic [79:0] in_data;
  logic [4:0]  in_ready;
  logic        out_valid;
  logic [15:0] out_data;
  logic [2:0]  out_src;
  logic        out_ready;
  logic [2:0]  fill_level;

  int vectors     = 0;
  int miscompares = 0;

  logic [18:0] sb_q [$];
  int          m_ptr = 0;

  leaf_stream_collector dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_ready   (in_ready),
    .out_valid  (out_valid),
    .out_data   (out_data),
    .out_src    (out_src),
    .out_ready  (out_ready),
    .fill_level (fill_level)
  );

  always #5 clk = ~clk;

  // Reference monitor: predicts grants, occupancy and output order.
  int          g;
  int          idx;
  logic [4:0]  exp_rdy;
  logic [18:0] head;
  always @(negedge clk) begin
    if (rst) begin
      sb_q.delete();
      m_ptr = 0;
      vectors++;
      if (in_ready !== 5'b0 || out_valid !== 1'b0 || fill_level !== 3'd0) begin
        miscompares++;
        $display("FAIL mon_reset rdy=%b ov=%b fill=%0d want 0/0/0",
                 in_ready, out_valid, fill_level);
      end
    end else begin
      g = -1;
      exp_rdy = '0;
      if (sb_q.size() < 4) begin
        for (int k = 0; k < 5; k++) begin
          idx = (m_ptr + k) % 5;
          if (g < 0 && in_valid[idx]) g = idx;
        end
      end
      if (g >= 0) exp_rdy[g] = 1'b1;
      vectors++;
      if (in_ready !== exp_rdy) begin
        miscompares++;
        $display("FAIL mon_ready got=%b want=%b", in_ready, exp_rdy);
      end
      vectors++;
      if (fill_level !== 3'(sb_q.size())) begin
        miscompares++;
        $display("FAIL mon_fill got=%0d want=%0d", fill_level, sb_q.size());
      end
      vectors++;
      if (out_valid !== (sb_q.size() != 0)) begin
        miscompares++;
        $display("FAIL mon_valid got=%b want=%b", out_valid, sb_q.size() != 0);
      end
      if (sb_q.size() != 0 && out_ready) begin
        head = sb_q.pop_front();
        vectors++;
        if ({out_src, out_data} !== head) begin
          miscompares++;
          $display("FAIL mon_data got=%0d:%h want=%0d:%h",
                   out_src, out_data, head[18:16], head[15:0]);
        end
      end
      if (g >= 0) begin
        sb_q.push_back({3'(g), in_data[g*16 +: 16]});
        m_ptr = (g + 1) % 5;
      end
    end
  end

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1;
    in_valid = '0;
    out_ready = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic drain();
    in_valid = '0;
    out_ready = 1'b1;
    repeat (12) @(posedge clk);
    #1 out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    in_valid = 5'h1f;
    in_data = {5{16'h5a5a}};
    out_ready = 1'b1;
    repeat (2) @(negedge clk);
    vectors++;
    if (out_valid !== 1'b0 || fill_level !== 3'd0 || in_ready !== 5'b0 ||
        out_data !== 16'h0 || out_src !== 3'd0) begin
      miscompares++;
      $display("FAIL reset_state ov=%b fill=%0d rdy=%b d=%h s=%0d want all 0",
               out_valid, fill_level, in_ready, out_data, out_src);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    out_ready = 1'b0;
    in_valid = 5'b00001;
    in_data[15:0] = 16'h0101;
    @(posedge clk); #1 in_data[15:0] = 16'h0102;
    @(posedge clk); #1 in_data[15:0] = 16'h0103;
    @(posedge clk); #1 in_valid = '0;
    @(negedge clk);
    vectors++;
    if (fill_level !== 3'd3) begin
      miscompares++;
      $display("FAIL reset_prefill got=%0d want=3", fill_level);
    end
    @(posedge clk); #1;
    in_valid = 5'b00001;
    in_data[15:0] = 16'h0104;
    rst = 1'b1;
    #1;
    vectors++;
    if (fill_level !== 3'd0 || out_valid !== 1'b0 || in_ready !== 5'b0) begin
      miscompares++;
      $display("FAIL reset_mid fill=%0d ov=%b rdy=%b want 0/0/0",
               fill_level, out_valid, in_ready);
    end
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    vectors++;
    if (in_ready !== 5'b00001) begin
      miscompares++;
      $display("FAIL reset_release got=%b want=00001", in_ready);
    end
    @(posedge clk); #1;
    drain();
  endtask

  task automatic test_fairness();
    int k = 0;
    int cyc = 0;
    int cnt [5];
    logic [4:0] acc;
    do_reset();
    for (int i = 0; i < 5; i++) begin
      cnt[i] = 0;
      in_data[i*16 +: 16] = 16'hF000 | 16'(i << 8);
    end
    in_valid = 5'h1f;
    out_ready = 1'b1;
    while (k < 7 && cyc < 40) begin
      @(negedge clk);
      acc = in_valid & in_ready;
      if (out_valid) begin
        vectors++;
        if (out_src !== 3'(k % 5) ||
            out_data !== (16'hF000 | 16'((k % 5) << 8) | 16'(k / 5))) begin
          miscompares++;
          $display("FAIL fair_%0d got=%0d:%h want=%0d:%h", k, out_src, out_data,
                   k % 5, 16'hF000 | 16'((k % 5) << 8) | 16'(k / 5));
        end
        k++;
      end
      @(posedge clk); #1;
      for (int i = 0; i < 5; i++) begin
        if (acc[i]) begin
          cnt[i]++;
          in_data[i*16 +: 16] = 16'hF000 | 16'(i << 8) | 16'(cnt[i]);
        end
      end
      cyc++;
    end
    vectors++;
    if (k < 7) begin
      miscompares++;
      $display("FAIL fair_timeout got=%0d words want=7", k);
    end
    drain();
  endtask

  task automatic test_wrap();
    do_reset();
    out_ready = 1'b1;
    in_valid = 5'b01000;
    in_data[63:48] = 16'hC003;
    @(negedge clk);
    vectors++;
    if (in_ready !== 5'b01000) begin
      miscompares++;
      $display("FAIL wrap_seed got=%b want=01000", in_ready);
    end
    @(posedge clk); #1;
    in_valid = 5'b01010;
    in_data[31:16] = 16'hC101;
    in_data[63:48] = 16'hC103;
    @(negedge clk);
    vectors++;
    if (in_ready !== 5'b00010) begin
      miscompares++;
      $display("FAIL wrap_ptr4 got=%b want=00010", in_ready);
    end
    @(posedge clk); #1 in_data[31:16] = 16'hC102;
    @(negedge clk);
    vectors++;
    if (in_ready !== 5'b01000) begin
      miscompares++;
      $display("FAIL wrap_ptr2 got=%b want=01000", in_ready);
    end
    @(posedge clk); #1 in_data[63:48] = 16'hC104;
    @(negedge clk);
    vectors++;
    if (in_ready !== 5'b00010) begin
      miscompares++;
      $display("FAIL wrap_again got=%b want=00010", in_ready);
    end
    @(posedge clk); #1;
    drain();
  endtask

  task automatic test_full();
    do_reset();
    in_valid = 5'b00100;
    in_data[47:32] = 16'hA001;
    for (int n = 1; n <= 4; n++) begin
      @(posedge clk); #1 in_data[47:32] = 16'hA001 + 16'(n);
    end
    @(negedge clk);
    vectors++;
    if (fill_level !== 3'd4 || in_ready !== 5'b0) begin
      miscompares++;
      $display("FAIL full_stall fill=%0d rdy=%b want 4/00000", fill_level, in_ready);
    end
    @(posedge clk); #1 out_ready = 1'b1;
    @(negedge clk);
    vectors++;
    if (in_ready !== 5'b0) begin
      miscompares++;
      $display("FAIL full_pop_cycle got=%b want=00000", in_ready);
    end
    @(posedge clk); #1 out_ready = 1'b0;
    @(negedge clk);
    vectors++;
    if (fill_level !== 3'd3 || in_ready !== 5'b00100) begin
      miscompares++;
      $display("FAIL full_reopen fill=%0d rdy=%b want 3/00100", fill_level, in_ready);
    end
    @(posedge clk); #1;
    in_valid = '0;
    out_ready = 1'b1;
    for (int j = 0; j < 4; j++) begin
      @(negedge clk);
      vectors++;
      if (out_data !== 16'hA002 + 16'(j) || out_src !== 3'd2) begin
        miscompares++;
        $display("FAIL full_order_%0d got=%0d:%h want=2:%h",
                 j, out_src, out_data, 16'hA002 + 16'(j));
      end
      @(posedge clk); #1;
    end
    drain();
  endtask

  task automatic test_simul();
    do_reset();
    in_valid = 5'b00001;
    in_data[15:0] = 16'hB001;
    @(posedge clk); #1 in_data[15:0] = 16'hB002;
    @(posedge clk); #1;
    in_data[15:0] = 16'hB003;
    out_ready = 1'b1;
    @(negedge clk);
    vectors++;
    if (fill_level !== 3'd2 || out_data !== 16'hB001) begin
      miscompares++;
      $display("FAIL simul_pre fill=%0d d=%h want 2/b001", fill_level, out_data);
    end
    @(posedge clk); #1;
    in_valid = '0;
    out_ready = 1'b0;
    @(negedge clk);
    vectors++;
    if (fill_level !== 3'd2 || out_data !== 16'hB002) begin
      miscompares++;
      $display("FAIL simul_post fill=%0d d=%h want 2/b002", fill_level, out_data);
    end
    drain();
  endtask

  task automatic test_latency();
    do_reset();
    in_valid = 5'b10000;
    in_data[79:64] = 16'h1234;
    @(negedge clk);
    vectors++;
    if (out_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL lat_before got=%b want=0", out_valid);
    end
    @(posedge clk); #1;
    in_valid = '0;
    vectors++;
    if (out_valid !== 1'b1 || out_data !== 16'h1234 || out_src !== 3'd4) begin
      miscompares++;
      $display("FAIL lat_after ov=%b d=%h s=%0d want 1/1234/4",
               out_valid, out_data, out_src);
    end
    drain();
  endtask

  task automatic test_back_to_back();
    int accepted = 0;
    int popped = 0;
    logic [4:0] acc;
    do_reset();
    for (int c = 0; c < 300; c++) begin
      @(negedge clk);
      acc = in_valid & in_ready;
      accepted += $countones(acc);
      if (out_valid && out_ready) popped++;
      @(posedge clk); #1;
      for (int i = 0; i < 5; i++) begin
        if (acc[i]) in_valid[i] = 1'b0;
        if (!in_valid[i] && $urandom_range(0, 2) == 0) begin
          in_valid[i] = 1'b1;
          in_data[i*16 +: 16] = 16'($urandom);
        end
      end
      out_ready = $urandom_range(0, 3) != 0;
    end
    in_valid = '0;
    out_ready = 1'b1;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (out_valid && out_ready) popped++;
      @(posedge clk); #1;
    end
    vectors++;
    if (popped !== accepted || fill_level !== 3'd0) begin
      miscompares++;
      $display("FAIL b2b_count popped=%0d fill=%0d want %0d/0",
               popped, fill_level, accepted);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_fairness();
    test_wrap();
    test_full();
    test_simul();
    test_latency();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
